// File: rtl/gat_feat_stream_reader.sv
// gat_feat_stream_reader: sweeps the feature BRAM and streams every word out over AXI-Stream with credit-based latency absorption
module gat_feat_stream_reader #(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NUM_SUBGRAPHS      = 2708,
    parameter int NUM_FEATURE_OUT    = 16,
    parameter int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int BRAM_LATENCY       = 2,
    parameter int FIFO_DEPTH         = BRAM_LATENCY + 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NEW_FEATURE_ADDR_W:0]   rd_len,
    input  logic                          gat_ready,
    output logic                          busy,
    output logic                          done,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast
);
    localparam int LW = NEW_FEATURE_ADDR_W + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM, S_DONE} state_t;
    state_t                       state_q;
    logic [LW-1:0]                len_q, issue_cnt_q, pop_cnt_q, len_clamped;
    logic [BRAM_LATENCY-1:0]      pipe_q;
    logic [CW-1:0]                fifo_cnt_q, inflight;
    logic [CW:0]                  occ;
    logic [PW-1:0]                wr_ptr_q, rd_ptr_q;
    logic [NEW_FEATURE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [LW+1:0]                addr_q;
    logic                         pop, push, issue, last_word;
    always_comb begin
        inflight = '0;
        for (int i = 0; i < BRAM_LATENCY; i++) inflight = inflight + CW'(pipe_q[i]);
    end
    assign len_clamped     = rd_len > LW'(NEW_FEATURE_DEPTH) ? LW'(NEW_FEATURE_DEPTH) : rd_len;
    assign m_axis_tvalid   = fifo_cnt_q != '0;
    assign m_axis_tdata    = mem_q[rd_ptr_q];
    assign last_word       = pop_cnt_q == len_q - LW'(1);
    assign m_axis_tlast    = m_axis_tvalid && last_word;
    assign pop             = m_axis_tvalid && m_axis_tready;
    assign push            = pipe_q[BRAM_LATENCY-1];
    // words in flight plus buffered words, net of this cycle's pop, must leave room for a new read
    assign occ             = (CW+1)'(inflight) + (CW+1)'(fifo_cnt_q) - (CW+1)'(pop);
    assign issue           = state_q == S_STREAM && gat_ready && issue_cnt_q < len_q && occ < (CW+1)'(FIFO_DEPTH);
    assign busy            = state_q == S_WAIT || state_q == S_STREAM;
    assign done            = state_q == S_DONE;
    assign feat_bram_addrb = addr_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            issue_cnt_q <= '0;
            pop_cnt_q   <= '0;
            pipe_q      <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            addr_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pipe_q     <= (pipe_q << 1) | BRAM_LATENCY'(issue);
            fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
            if (issue) begin
                addr_q      <= {issue_cnt_q[NEW_FEATURE_ADDR_W-1:0], 2'b00};
                issue_cnt_q <= issue_cnt_q + LW'(1);
            end
            if (push) begin
                mem_q[wr_ptr_q] <= feat_bram_dout;
                wr_ptr_q        <= wr_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr_q + PW'(1);
                pop_cnt_q <= pop_cnt_q + LW'(1);
            end
            case (state_q)
                S_IDLE: if (start) begin
                    len_q       <= len_clamped;
                    issue_cnt_q <= '0;
                    pop_cnt_q   <= '0;
                    state_q     <= len_clamped == '0 ? S_DONE : S_WAIT;
                end
                S_WAIT:   state_q <= gat_ready ? S_STREAM : S_WAIT;
                S_STREAM: state_q <= pop && last_word ? S_DONE : S_STREAM;
                default:  state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gat_feat_stream_reader.sv
// tb_gat_feat_stream_reader: directed scenarios for the feature stream reader with a word-index BRAM model
module tb_gat_feat_stream_reader;
    localparam int AW = 16;
    localparam int L  = 2;
    logic          clk = 0, rst = 1, start = 0, gat_ready = 1, tready = 1;
    logic [AW:0]   rd_len = '0;
    logic          busy, done, tvalid, tlast;
    logic [AW+1:0] addrb;
    logic [31:0]   dout, tdata, bram_q;
    int            vecs = 0, fails = 0;
    logic [31:0]   got[$];
    bit            lasts[$];
    int            stab_err, first_c, last_c;
    bit            done_seen;

    gat_feat_stream_reader #(.BRAM_LATENCY(L)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_len(rd_len), .gat_ready(gat_ready),
        .busy(busy), .done(done), .feat_bram_addrb(addrb), .feat_bram_dout(dout),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
    );

    always #5 clk = ~clk;
    always_ff @(posedge clk) bram_q <= 32'(addrb[AW+1:2]);
    assign dout = bram_q;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start  = 1;
        rd_len = (AW+1)'(len);
        tick;
        start = 0;
    endtask

    task automatic drain(input int max_cyc, input int pct);
        bit          held = 0, hl = 0;
        logic [31:0] hd = '0;
        got.delete();
        lasts.delete();
        stab_err = 0; done_seen = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < max_cyc && !done_seen; c++) begin
            tready = ($urandom_range(0, 99) < pct);
            if (done) done_seen = 1;
            else if (tvalid) begin
                if (held && (tdata !== hd || tlast !== hl)) stab_err++;
                if (tready) begin
                    got.push_back(tdata);
                    lasts.push_back(tlast);
                    if (first_c < 0) first_c = c;
                    last_c = c;
                    held = 0;
                end else begin
                    held = 1; hd = tdata; hl = tlast;
                end
            end else if (held) stab_err++;
            if (!done_seen) tick;
        end
    endtask

    task automatic check_words(input string name, input int n);
        int derr = 0, lerr = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== 32'(i)) derr++;
            if (lasts[i] !== (i == n - 1)) lerr++;
        end
        vecs++; if (got.size() !== n) begin fails++; $display("FAIL %s count: got %0d want %0d", name, got.size(), n); end
        vecs++; if (derr !== 0) begin fails++; $display("FAIL %s data: %0d bad words want 0", name, derr); end
        vecs++; if (lerr !== 0) begin fails++; $display("FAIL %s tlast: %0d bad flags want 0", name, lerr); end
        vecs++; if (stab_err !== 0) begin fails++; $display("FAIL %s stall stability: %0d errors want 0", name, stab_err); end
        vecs++; if (!done_seen) begin fails++; $display("FAIL %s done: got 0 want 1", name); end
    endtask

    task automatic test_reset;
        vecs++; if (busy !== 0) begin fails++; $display("FAIL reset busy: got %b want 0", busy); end
        vecs++; if (done !== 0) begin fails++; $display("FAIL reset done: got %b want 0", done); end
        vecs++; if (tvalid !== 0) begin fails++; $display("FAIL reset tvalid: got %b want 0", tvalid); end
        vecs++; if (tlast !== 0) begin fails++; $display("FAIL reset tlast: got %b want 0", tlast); end
        vecs++; if (addrb !== '0) begin fails++; $display("FAIL reset addrb: got %h want 0", addrb); end
        vecs++; if (tdata !== '0) begin fails++; $display("FAIL reset tdata: got %h want 0", tdata); end
    endtask

    task automatic test_timing;
        tready = 1; gat_ready = 1;
        do_start(3);
        for (int c = 1; c <= 9; c++) begin
            vecs++; if (busy !== (c <= 7)) begin fails++; $display("FAIL timing busy c%0d: got %b want %b", c, busy, c <= 7); end
            vecs++; if (tvalid !== (c >= 5 && c <= 7)) begin fails++; $display("FAIL timing tvalid c%0d: got %b want %b", c, tvalid, c >= 5 && c <= 7); end
            vecs++; if (tlast !== (c == 7)) begin fails++; $display("FAIL timing tlast c%0d: got %b want %b", c, tlast, c == 7); end
            vecs++; if (done !== (c == 8)) begin fails++; $display("FAIL timing done c%0d: got %b want %b", c, done, c == 8); end
            if (c >= 5 && c <= 7) begin
                vecs++; if (tdata !== 32'(c - 5)) begin fails++; $display("FAIL timing tdata c%0d: got %0d want %0d", c, tdata, c - 5); end
            end
            tick;
        end
        vecs++; if (addrb !== 18'h8) begin fails++; $display("FAIL timing last addrb: got %h want 8", addrb); end
    endtask

    task automatic test_zero_len;
        do_start(0);
        vecs++; if (done !== 1) begin fails++; $display("FAIL zero done c1: got %b want 1", done); end
        vecs++; if (busy !== 0) begin fails++; $display("FAIL zero busy c1: got %b want 0", busy); end
        vecs++; if (tvalid !== 0) begin fails++; $display("FAIL zero tvalid c1: got %b want 0", tvalid); end
        tick;
        vecs++; if (done !== 0) begin fails++; $display("FAIL zero done c2: got %b want 0", done); end
        vecs++; if (tvalid !== 0) begin fails++; $display("FAIL zero tvalid c2: got %b want 0", tvalid); end
    endtask

    task automatic test_gat_wait;
        logic [AW+1:0] prev;
        int            errs = 0;
        prev = addrb;
        gat_ready = 0; tready = 1;
        do_start(2);
        for (int c = 1; c < 20; c++) begin
            if (addrb !== prev || tvalid !== 0) errs++;
            tick;
        end
        vecs++; if (errs !== 0) begin fails++; $display("FAIL gat_wait idle: %0d changes want 0", errs); end
        gat_ready = 1;
        errs = 0;
        for (int c = 20; c < 24; c++) begin
            if (tvalid !== 0) errs++;
            if (c == 22 && addrb !== '0) errs++;
            tick;
        end
        vecs++; if (errs !== 0) begin fails++; $display("FAIL gat_wait latency: %0d errors want 0", errs); end
        vecs++; if (tvalid !== 1 || tdata !== '0) begin fails++; $display("FAIL gat_wait first word: tvalid %b tdata %0d want 1 0", tvalid, tdata); end
        drain(50, 100);
        check_words("gat_wait", 2);
    endtask

    task automatic test_busy_start;
        tready = 1;
        do_start(6);
        tick; tick;
        start = 1; rd_len = 2;
        tick;
        start = 0;
        vecs++; if (busy !== 1) begin fails++; $display("FAIL busy_start busy: got %b want 1", busy); end
        drain(100, 100);
        check_words("busy_start", 6);
    endtask

    task automatic test_backpressure;
        do_start(8);
        drain(600, 30);
        check_words("backpressure", 8);
    endtask

    task automatic test_mid_reset;
        int n = 0;
        tready = 1;
        do_start(20);
        for (int c = 0; c < 60 && n < 5; c++) begin
            if (tvalid) n++;
            tick;
        end
        tready = 0;
        vecs++; if (n !== 5) begin fails++; $display("FAIL mid_reset words before reset: got %0d want 5", n); end
        repeat (6) tick;
        rst = 1;
        tick;
        vecs++; if (tvalid !== 0) begin fails++; $display("FAIL mid_reset tvalid: got %b want 0", tvalid); end
        vecs++; if (busy !== 0) begin fails++; $display("FAIL mid_reset busy: got %b want 0", busy); end
        rst = 0;
        tick;
        do_start(4);
        drain(100, 100);
        check_words("mid_reset restart", 4);
    endtask

    task automatic test_full_sweep;
        do_start(60000);
        drain(43500, 100);
        check_words("full_sweep", 43328);
        vecs++; if (last_c - first_c + 1 !== got.size()) begin fails++; $display("FAIL full_sweep bubbles: span %0d want %0d", last_c - first_c + 1, got.size()); end
        vecs++; if (addrb !== 18'h2A4FC) begin fails++; $display("FAIL full_sweep last addrb: got %h want 2a4fc", addrb); end
    endtask

    initial begin
        repeat (3) tick;
        test_reset;
        rst = 0;
        tick;
        test_timing;
        test_zero_len;
        tick;
        test_gat_wait;
        tick;
        test_busy_start;
        tick;
        test_backpressure;
        tick;
        test_mid_reset;
        tick;
        test_full_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule

// File: doc/gat_feat_stream_reader.md
# gat_feat_stream_reader

Read-side engine for the new-feature BRAM. It sits between the GAT core's `feat_bram_addrb`/`feat_bram_dout` read port and the PS-facing AXI-Stream DMA. After a software `start` and once the core asserts `gat_ready`, it sweeps the feature BRAM with word-aligned byte addresses and absorbs the fixed BRAM read latency. It emits every word in address order on a back-pressurable stream, with `tlast` on the final word.

## Interface
- `NEW_FEATURE_WIDTH`, 32: feature word width.
- `NUM_SUBGRAPHS`, 2708: subgraph count.
- `NUM_FEATURE_OUT`, 16: output features per subgraph.
- `NEW_FEATURE_DEPTH`, `NUM_SUBGRAPHS*NUM_FEATURE_OUT`: words in the feature BRAM.
- `NEW_FEATURE_ADDR_W`, `$clog2(NEW_FEATURE_DEPTH)`: word-address width.
- `BRAM_LATENCY`, 2: cycles from address register to valid `feat_bram_dout`. Legal range is 1..4.
- `FIFO_DEPTH`, `BRAM_LATENCY+2`: output buffer entries.

Ports:
- `clk` input 1: single clock.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle request to begin a sweep. It is ignored while `busy`.
- `rd_len` input `NEW_FEATURE_ADDR_W+1`: word count, sampled on an accepted `start`. The value is clamped to `NEW_FEATURE_DEPTH`.
- `gat_ready` input 1: core-finished flag. Reads are not issued while it is low.
- `busy` output 1: high from accepted `start` until the last word handshakes.
- `done` output 1: one-cycle pulse after the last word handshakes, or immediately for `rd_len==0`.
- `feat_bram_addrb` output `NEW_FEATURE_ADDR_W+2`: byte address, `{word_addr, 2'b00}`.
- `feat_bram_dout` input `NEW_FEATURE_WIDTH`: BRAM read data, always enabled.
- `m_axis_tdata` output `NEW_FEATURE_WIDTH`: stream data.
- `m_axis_tvalid` output 1: stream valid.
- `m_axis_tready` input 1: stream ready.
- `m_axis_tlast` output 1: high with the final word of the sweep.

## Operation
- States:
  - IDLE: `start` with `rd_len` clamped to a nonzero value goes to WAIT; `start` with `rd_len==0` goes to DONE.
  - WAIT: waits for `gat_ready`, then goes to STREAM.
  - STREAM: issues reads. It goes to DONE when the final word handshakes.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Counters:
  - `issue_cnt`: reads issued.
  - `pop_cnt`: words handshaken.
  - `inflight`: count of set bits in a `BRAM_LATENCY`-deep issue shift register.
  - `fifo_cnt`: occupied buffer entries.
- Issue rule (STREAM only): a read is issued in a cycle when `gat_ready` is 1, `issue_cnt < len`, and `inflight + fifo_cnt - pop_this_cycle < FIFO_DEPTH`.
  - An issued read registers `word_addr = issue_cnt` into `feat_bram_addrb` and shifts a 1 into the issue pipe. Otherwise a 0 is shifted in.
  - The credit rule guarantees no overflow. A returning word is never dropped.
- Return: when the pipe tail is 1, `feat_bram_dout` is written into the FIFO in that cycle.
- Output:
  - The FIFO head drives `m_axis_tdata`. `m_axis_tvalid = fifo_cnt!=0`.
  - `m_axis_tlast = m_axis_tvalid && pop_cnt==len-1`.
  - Data and tlast hold stable while `tvalid && !tready`.
- Simultaneous FIFO push and pop in one cycle: both occur and `fifo_cnt` is unchanged.
- `gat_ready` falling in STREAM: issue pauses. In-flight words still land and drain.
- Address wrap: `issue_cnt` never exceeds `len-1`, so `word_addr` never wraps past `NEW_FEATURE_DEPTH-1`.
- Reset (including mid-sweep) clears all state to IDLE and flushes the pipe and FIFO. Partial data is discarded.
- Reset values:
  - `busy`, `done`, `m_axis_tvalid`, `m_axis_tlast` = 0.
  - `feat_bram_addrb` = 0.
  - `m_axis_tdata` = 0.

## Timing
- An accepted `start` at cycle 0 gives `busy`=1 at cycle 1.
- With `gat_ready` already high: first address registered at cycle 2, data captured at cycle 2+`BRAM_LATENCY`, `m_axis_tvalid` at cycle 3+`BRAM_LATENCY`.
- Steady throughput with `tready` held high is one word per cycle. There are no bubbles after the first word.
- `done` pulses the cycle after the last `tvalid&&tready`. `busy` drops in the same cycle `done` is high.
- For `rd_len==0`: `done` at cycle 1, with no stream traffic.
- `tvalid` is never withdrawn without a handshake.

## Test plan
- Full sweep, `rd_len=43328`, `tready`=1, BRAM preloaded with data=word index.
  - Required: 43328 words 0..43327 in order at one per cycle.
  - Required: `tlast` only on 43327; `done` one cycle later.
  - Required: last `feat_bram_addrb`=0x2A4FC.
- `rd_len=8`, `tready` toggling with a random 30% duty.
  - Required: exactly 8 words 0..7 in order, none duplicated.
  - Required: FIFO never exceeds `FIFO_DEPTH`; data stable during stalls.
- `gat_ready`=0 at `start`, raised 20 cycles later.
  - Required: no address change before `gat_ready`.
  - Required: first `tvalid` at `BRAM_LATENCY+1` cycles after the first issue.
- `rd_len=0`, and separately `rd_len=60000`.
  - Required for `rd_len=0`: `done` at cycle 1 with no `tvalid`.
  - Required for `rd_len=60000`: clamped to 43328 words.
- `rst` asserted after 5 words with `tready`=0.
  - Required next cycle: `tvalid`=0, `busy`=0.
  - Required: a new `start` with `rd_len=4` streams words 0..3 cleanly.
- `start` pulsed while busy.
  - Required: ignored, and the current sweep count is unchanged.
